fpadd_arbiter: RTL

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

---
 rtl/fpadd_arbiter_if.sv | 32 +++
 rtl/fpadd_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/fpadd_arbiter_if.sv
// Requester, response and adder-side signals of the two-port FP add arbiter.
// Handshake: a request transfers in a cycle where reqN_valid and reqN_ready are both high; rspN_valid is a one-cycle pulse with no backpressure.
interface fpadd_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic        rsp0_valid;
  logic [31:0] rsp0_result;
  logic        rsp1_valid;
  logic [31:0] rsp1_result;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_result;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_result,
    output req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
           add_a, add_b, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
           add_a, add_b, busy
  );
endinterface

// File: rtl/fpadd_arbiter.sv
// Round-robin share of one fixed-latency FP adder between two requesters.
// A tag shift register tracks which requester owns each in-flight add.
module fpadd_arbiter #(
  parameter int LAT = 2
) (
  input logic            clk,
  input logic            reset,
  fpadd_arbiter_if.slave bus
);
  localparam int TD = LAT + 1;
  localparam int CW = $clog2(LAT + 2);

  logic          last_grant_q, last_grant_d;
  logic [31:0]   add_a_q, add_a_d;
  logic [31:0]   add_b_q, add_b_d;
  logic [TD-1:0] tvld_q, tvld_d;
  logic [TD-1:0] tid_q, tid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hold0_q, hold0_d;
  logic [31:0]   hold1_q, hold1_d;

  logic grant;
  logic rdy0, rdy1, xfer;
  logic rsp0, rsp1;

  always_comb begin
    // Under contention the requester that did not win last time is served.
    grant = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    rdy0  = !reset && bus.req0_valid && !grant;
    rdy1  = !reset && bus.req1_valid && grant;
    xfer  = rdy0 || rdy1;
    rsp0  = !reset && tvld_q[TD-1] && !tid_q[TD-1];
    rsp1  = !reset && tvld_q[TD-1] && tid_q[TD-1];

    last_grant_d = xfer ? grant : last_grant_q;
    add_a_d = 32'h0;
    add_b_d = 32'h0;
    if (rdy0) begin
      add_a_d = bus.req0_a;
      add_b_d = bus.req0_b;
    end else if (rdy1) begin
      add_a_d = bus.req1_a;
      add_b_d = bus.req1_b;
    end

    tvld_d    = tvld_q;
    tid_d     = tid_q;
    tvld_d[0] = xfer;
    tid_d[0]  = grant;
    for (int i = 1; i < TD; i++) begin
      tvld_d[i] = tvld_q[i-1];
      tid_d[i]  = tid_q[i-1];
    end

    cnt_d = cnt_q;
    case ({xfer, rsp0 || rsp1})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    hold0_d = rsp0 ? bus.add_result : hold0_q;
    hold1_d = rsp1 ? bus.add_result : hold1_q;

    bus.req0_ready  = rdy0;
    bus.req1_ready  = rdy1;
    bus.rsp0_valid  = rsp0;
    bus.rsp1_valid  = rsp1;
    bus.rsp0_result = rsp0 ? bus.add_result : hold0_q;
    bus.rsp1_result = rsp1 ? bus.add_result : hold1_q;
    bus.add_a       = add_a_q;
    bus.add_b       = add_b_q;
    bus.busy        = (cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      add_a_q      <= 32'h0;
      add_b_q      <= 32'h0;
      tvld_q       <= '0;
      tid_q        <= '0;
      cnt_q        <= '0;
      hold0_q      <= 32'h0;
      hold1_q      <= 32'h0;
    end else begin
      last_grant_q <= last_grant_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      tvld_q       <= tvld_d;
      tid_q        <= tid_d;
      cnt_q        <= cnt_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
    end
  end
endmodule
